// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent SR storage bits with an elaboration-time conflict policy,
// edge pulses, sticky per-channel conflict flags and a saturating conflict-cycle counter.
module sr_reg_bank #(
  parameter int WIDTH         = 8,
  parameter int CONFLICT_MODE = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] conflict_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_val;
  logic [WIDTH-1:0] conflict_event;
  logic             inc;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      // Value taken by a channel when s and r are both asserted; unknown modes hold.
      if (CONFLICT_MODE == 1) begin : g_set
        assign conflict_val[gi] = 1'b1;
      end else if (CONFLICT_MODE == 2) begin : g_rst
        assign conflict_val[gi] = 1'b0;
      end else if (CONFLICT_MODE == 3) begin : g_tog
        assign conflict_val[gi] = ~q[gi];
      end else begin : g_hold
        assign conflict_val[gi] = q[gi];
      end

      assign conflict_event[gi] = en & s[gi] & r[gi];

      assign q_next[gi] = clr                  ? 1'b0 :
                          !en                  ? q[gi] :
                          (s[gi] && !r[gi])    ? 1'b1 :
                          (!s[gi] && r[gi])    ? 1'b0 :
                          (s[gi] && r[gi])     ? conflict_val[gi] :
                                                 q[gi];
    end
  endgenerate

  assign inc = |conflict_event;
  assign qn  = ~q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q            <= '0;
      rise         <= '0;
      fall         <= '0;
      conflict     <= '0;
      conflict_cnt <= '0;
    end else begin
      q        <= q_next;
      rise     <= q_next & ~q;
      fall     <= ~q_next & q;
      // A new event wins over a simultaneous clear of the sticky flag.
      conflict <= conflict_event | (conflict & ~conflict_clr);
      if (cnt_clr) begin
        conflict_cnt <= inc ? CNT_ONE : '0;
      end else if (inc && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sr_reg_bank.sv
// Bench for sr_reg_bank: four instances (conflict modes 0..3) plus a 2-bit-counter instance,
// all sharing stimulus and checked against a mask-arithmetic reference model.
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic       cnt_clr;
  logic [7:0] s;
  logic [7:0] r;
  logic [7:0] conflict_clr;

  logic [7:0] q_o    [5];
  logic [7:0] qn_o   [5];
  logic [7:0] rise_o [5];
  logic [7:0] fall_o [5];
  logic [7:0] conf_o [5];
  logic [7:0] cnt_o  [5];
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  logic [7:0] mq    [5];
  logic [7:0] mrise [5];
  logic [7:0] mfall [5];
  logic [7:0] mconf [5];
  int         mcnt  [5];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mode
      sr_reg_bank #(.WIDTH(8), .CONFLICT_MODE(gi), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
        .conflict_clr(conflict_clr), .cnt_clr(cnt_clr),
        .q(q_o[gi]), .qn(qn_o[gi]), .rise(rise_o[gi]), .fall(fall_o[gi]),
        .conflict(conf_o[gi]), .conflict_cnt(cnt_o[gi])
      );
    end
  endgenerate

  sr_reg_bank #(.WIDTH(8), .CONFLICT_MODE(0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
    .conflict_clr(conflict_clr), .cnt_clr(cnt_clr),
    .q(q_o[4]), .qn(qn_o[4]), .rise(rise_o[4]), .fall(fall_o[4]),
    .conflict(conf_o[4]), .conflict_cnt(cnt2)
  );
  assign cnt_o[4] = {6'd0, cnt2};

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      mq[k] = 8'h00; mrise[k] = 8'h00; mfall[k] = 8'h00; mconf[k] = 8'h00; mcnt[k] = 0;
    end
  endtask

  // Channel rules as whole-word masks: set-only bits go high, reset-only bits go low,
  // then the conflicting bits are patched according to each instance's policy.
  task automatic model_step();
    int         mode;
    int         maxc;
    logic [7:0] both;
    logic [7:0] nq;
    logic [7:0] ev;
    for (int k = 0; k < 5; k++) begin
      mode = (k == 4) ? 0 : k;
      maxc = (k == 4) ? 3 : 255;
      both = s & r;
      if (clr)      nq = 8'h00;
      else if (!en) nq = mq[k];
      else begin
        nq = (mq[k] | (s & ~r)) & ~(r & ~s);
        case (mode)
          1:       nq = nq | both;
          2:       nq = nq & ~both;
          3:       nq = nq ^ both;
          default: ;
        endcase
      end
      ev       = en ? both : 8'h00;
      mrise[k] = nq & ~mq[k];
      mfall[k] = ~nq & mq[k];
      mq[k]    = nq;
      mconf[k] = ev | (mconf[k] & ~conflict_clr);
      if (cnt_clr)                      mcnt[k] = (ev != 8'h00) ? 1 : 0;
      else if (ev != 8'h00 && mcnt[k] < maxc) mcnt[k] = mcnt[k] + 1;
    end
  endtask

  task automatic step(input logic e, input logic c, input logic [7:0] ss, input logic [7:0] rr,
                      input logic [7:0] cc, input logic kc);
    en = e; clr = c; s = ss; r = rr; conflict_clr = cc; cnt_clr = kc;
    model_step();
    @(posedge clk);
    #1;
    ncyc++;
    $display("cyc %0d en=%b clr=%b s=%h r=%h cclr=%h cntclr=%b | q0=%h conf0=%h cnt0=%0d cnt_sat=%0d",
             ncyc, e, c, ss, rr, cc, kc, q_o[0], conf_o[0], cnt_o[0], cnt_o[4]);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q_o[k] !== 8'h00 || qn_o[k] !== 8'hFF || conf_o[k] !== 8'h00 || cnt_o[k] !== 8'h00 ||
          rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00) begin
        errors++;
        $display("FAIL por_state dut%0d q=%h qn=%h conf=%h cnt=%0d rise=%h fall=%h required 00/FF/00/0/00/00",
                 k, q_o[k], qn_o[k], conf_o[k], cnt_o[k], rise_o[k], fall_o[k]);
      end
    end
    step(1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0);
    repeat (3) step(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0);
    checks++;
    if (q_o[0] !== 8'hA5 || conf_o[0] !== 8'h01 || cnt_o[0] !== 8'd3) begin
      errors++;
      $display("FAIL pre_reset q=%h conf=%h cnt=%0d required A5/01/3", q_o[0], conf_o[0], cnt_o[0]);
    end
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q_o[k] !== 8'h00 || qn_o[k] !== 8'hFF || conf_o[k] !== 8'h00 || cnt_o[k] !== 8'h00 ||
          rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00) begin
        errors++;
        $display("FAIL async_reset dut%0d q=%h qn=%h conf=%h cnt=%0d rise=%h fall=%h required 00/FF/00/0/00/00",
                 k, q_o[k], qn_o[k], conf_o[k], cnt_o[k], rise_o[k], fall_o[k]);
      end
    end
    model_reset();
    #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    step(1'b1, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0);
    checks++;
    if (q_o[0] !== 8'h0F || rise_o[0] !== 8'h0F || fall_o[0] !== 8'h00 || qn_o[0] !== 8'hF0) begin
      errors++;
      $display("FAIL basic_set q=%h qn=%h rise=%h fall=%h required 0F/F0/0F/00", q_o[0], qn_o[0], rise_o[0], fall_o[0]);
    end
    step(1'b1, 1'b0, 8'h00, 8'h03, 8'h00, 1'b0);
    checks++;
    if (q_o[0] !== 8'h0C || fall_o[0] !== 8'h03 || rise_o[0] !== 8'h00) begin
      errors++;
      $display("FAIL basic_reset q=%h rise=%h fall=%h required 0C/00/03", q_o[0], rise_o[0], fall_o[0]);
    end
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checks++;
    if (q_o[0] !== 8'h0C || rise_o[0] !== 8'h00 || fall_o[0] !== 8'h00) begin
      errors++;
      $display("FAIL basic_hold q=%h rise=%h fall=%h required 0C/00/00", q_o[0], rise_o[0], fall_o[0]);
    end
  endtask

  task automatic test_conflict_policy();
    logic expb;
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      expb = (k == 1 || k == 3);
      checks++;
      if (q_o[k][0] !== expb) begin
        errors++;
        $display("FAIL policy_mode%0d q0=%b required %b", k, q_o[k][0], expb);
      end
    end
    step(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0);
    checks++;
    if (q_o[3][0] !== 1'b0 || fall_o[3][0] !== 1'b1 || rise_o[3][0] !== 1'b0) begin
      errors++;
      $display("FAIL toggle_down q0=%b rise0=%b fall0=%b required 0/0/1", q_o[3][0], rise_o[3][0], fall_o[3][0]);
    end
    step(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0);
    checks++;
    if (q_o[3][0] !== 1'b1 || rise_o[3][0] !== 1'b1 || fall_o[3][0] !== 1'b0) begin
      errors++;
      $display("FAIL toggle_up q0=%b rise0=%b fall0=%b required 1/1/0", q_o[3][0], rise_o[3][0], fall_o[3][0]);
    end
  endtask

  task automatic test_enable_clear();
    step(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
    checks++;
    if (q_o[0] !== 8'hFF || fall_o[0] !== 8'h00) begin
      errors++;
      $display("FAIL en_hold q=%h fall=%h required FF/00", q_o[0], fall_o[0]);
    end
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    checks++;
    if (q_o[0] !== 8'h00 || fall_o[0] !== 8'hFF) begin
      errors++;
      $display("FAIL clr_no_en q=%h fall=%h required 00/FF", q_o[0], fall_o[0]);
    end
    step(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0);
    checks++;
    if (q_o[0] !== 8'h00 || rise_o[0] !== 8'h00) begin
      errors++;
      $display("FAIL clr_over_set q=%h rise=%h required 00/00", q_o[0], rise_o[0]);
    end
  endtask

  task automatic test_sticky_counter();
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1);
    repeat (3) step(1'b1, 1'b0, 8'h81, 8'h81, 8'h00, 1'b0);
    checks++;
    if (conf_o[0] !== 8'h81 || cnt_o[0] !== 8'd3) begin
      errors++;
      $display("FAIL sticky_set conf=%h cnt=%0d required 81/3", conf_o[0], cnt_o[0]);
    end
    step(1'b1, 1'b0, 8'h80, 8'h80, 8'h80, 1'b0);
    checks++;
    if (conf_o[0] !== 8'h81) begin
      errors++;
      $display("FAIL set_beats_clr conf=%h required 81", conf_o[0]);
    end
    step(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1);
    checks++;
    if (cnt_o[0] !== 8'd1) begin
      errors++;
      $display("FAIL cntclr_with_inc cnt=%0d required 1", cnt_o[0]);
    end
    step(1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0);
    checks++;
    if (conf_o[0] !== 8'h81 || cnt_o[0] !== 8'd1) begin
      errors++;
      $display("FAIL en_off_conflict conf=%h cnt=%0d required 81/1", conf_o[0], cnt_o[0]);
    end
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0);
    checks++;
    if (conf_o[0] !== 8'h80) begin
      errors++;
      $display("FAIL sticky_clear conf=%h required 80", conf_o[0]);
    end
  endtask

  task automatic test_saturation();
    int expc;
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    checks++;
    if (cnt_o[4] !== 8'd0) begin
      errors++;
      $display("FAIL sat_start cnt=%0d required 0", cnt_o[4]);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0);
      expc = (i + 1 > 3) ? 3 : i + 1;
      checks++;
      if (cnt_o[4] !== 8'(expc)) begin
        errors++;
        $display("FAIL sat_seq%0d cnt=%0d required %0d", i, cnt_o[4], expc);
      end
    end
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    checks++;
    if (cnt_o[4] !== 8'd0) begin
      errors++;
      $display("FAIL sat_clear cnt=%0d required 0", cnt_o[4]);
    end
  endtask

  task automatic test_random();
    logic [7:0] cc;
    for (int n = 0; n < 300; n++) begin
      cc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom), 8'($urandom),
           cc, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q_o[k] !== mq[k] || qn_o[k] !== ~mq[k]) begin
          errors++;
          $display("FAIL rand_q dut%0d q=%h qn=%h required %h", k, q_o[k], qn_o[k], mq[k]);
        end
        checks++;
        if (rise_o[k] !== mrise[k] || fall_o[k] !== mfall[k]) begin
          errors++;
          $display("FAIL rand_edge dut%0d rise=%h fall=%h required %h/%h", k, rise_o[k], fall_o[k], mrise[k], mfall[k]);
        end
        checks++;
        if (conf_o[k] !== mconf[k] || cnt_o[k] !== 8'(mcnt[k])) begin
          errors++;
          $display("FAIL rand_conf dut%0d conf=%h cnt=%0d required %h/%0d", k, conf_o[k], cnt_o[k], mconf[k], mcnt[k]);
        end
      end
      if (reset) #1 reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; cnt_clr = 1'b0;
    s = 8'h00; r = 8'h00; conflict_clr = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    test_reset();
    test_basic();
    test_conflict_policy();
    test_enable_clear();
    test_sticky_counter();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_reg_bank.md
Name: sr_reg_bank

Overview:
- Parametrised, multi-channel successor to the single-bit SR flip-flop: WIDTH independent SR storage bits sharing one clock.
- Set/reset conflict policy selectable at elaboration, instead of driving X on a conflict.
- Adds a global enable and synchronous clear, per-channel registered rise/fall pulses, per-channel sticky conflict flags and a saturating conflict-cycle counter.
- Used as a status/flag register bank in control paths.

Parameters:
- WIDTH, 8, number of SR channels (>=1).
- CONFLICT_MODE, 0, action on s=r=1: 0=hold, 1=set-dominant, 2=reset-dominant, 3=toggle. Any other value behaves as 0.
- CNT_W, 8, width of conflict_cnt (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  channel update enable.
- clr  input  1  synchronous clear of all q bits (takes priority over en).
- s  input  WIDTH  per-channel set.
- r  input  WIDTH  per-channel reset.
- conflict_clr  input  WIDTH  per-channel clear of the sticky conflict flag.
- cnt_clr  input  1  synchronous clear of conflict_cnt.
- q  output  WIDTH  stored state (registered).
- qn  output  WIDTH  ~q (combinational from q).
- rise  output  WIDTH  registered one-cycle pulse: q bit went 0->1 on this edge.
- fall  output  WIDTH  registered one-cycle pulse: q bit went 1->0 on this edge.
- conflict  output  WIDTH  sticky: channel saw s=r=1 while en=1.
- conflict_cnt  output  CNT_W  count of enabled cycles with at least one conflicting channel, saturating.

Behaviour:
- Reset (async, any time, including mid-operation): q=0, qn=all ones, rise=0, fall=0, conflict=0, conflict_cnt=0. Deassertion takes effect at the next rising clk.
- All state updates on rising clk. Latency: an input change is reflected on q one edge later. rise/fall are valid in the same cycle q shows the change.
- q_next per channel i:
  - clr=1: 0, regardless of en, s, r.
  - else en=0: q[i] (hold).
  - else {s,r}=00: hold; 10: 1; 01: 0.
  - else {s,r}=11: per CONFLICT_MODE — hold / 1 / 0 / ~q[i].
- rise <= q_next & ~q; fall <= ~q_next & q.
  - On any edge where q does not change, both are 0.
  - clr with q bits set gives fall=1 on those bits.
- Conflict event on channel i = en & s[i] & r[i]. clr does not suppress conflict detection.
- Sticky flag: conflict[i] <= event | (conflict[i] & ~conflict_clr[i]). Set wins over a simultaneous clear.
- conflict_cnt: inc = OR of all conflict events.
  - Multiple channels conflicting in one cycle count as 1.
  - cnt_clr=1 with inc=1: result 1. cnt_clr=1 with inc=0: result 0.
  - Otherwise increments by 1 when inc=1, saturating at 2^CNT_W-1 with no wrap.
- en=0: no conflicts recorded and no q changes (except by clr). rise/fall are 0 unless clr changes q.
- No X is ever produced on any output for any input combination.

Test Plan:
- Reset: assert reset mid-stream with q=8'hA5, conflict=8'h01, cnt=3 -> immediately q=00, qn=FF, conflict=00, cnt=0, rise=fall=00, without waiting for a clock.
- Basic SR with WIDTH=8, mode 0: en=1, s=0F, r=00 -> q=0F, rise=0F. Next s=00, r=03 -> q=0C, fall=03. Next s=r=00 -> q=0C, rise=fall=00.
- Conflict policy: q=00, s=r=01 for one cycle each under modes 0/1/2/3 -> q[0] = 0/1/0/1. Mode 3, two further conflict cycles -> q[0] toggles 0 then 1, with matching fall/rise pulses.
- Enable/clear priority: q=FF, en=0, s=00, r=FF -> q stays FF. Then clr=1, en=0 -> q=00, fall=FF. clr=1 with s=FF, en=1 -> q=00.
- Sticky flag and counter: en=1, s=r=81 for 3 cycles -> conflict=81, cnt=3. conflict_clr=80 with s=r=80 in the same cycle -> conflict stays 81. cnt_clr plus a conflict in the same cycle -> cnt=1. en=0 with s=r=FF -> no change to conflict or cnt.
- Saturation: CNT_W=2, 6 consecutive conflict cycles -> cnt sequence 1,2,3,3,3,3. Then cnt_clr with no conflict -> 0.
